// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------
// debounce_pkg: shared state encodings and default parameters
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

`default_nettype wire

// File: rtl/input_debouncer_sync_chain.sv
// ---------------------------------------------------------------
// sync_chain: multi-flop synchroniser, async active-low reset to 0
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------
// input_debouncer: synchronise, qualify level changes, flag edges
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s_w;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;

  sync_chain #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (d_in),
    .q_o   (s_w)
  );

  // Pulses default low every cycle so they can never stretch beyond one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (s_w) begin
            state_q <= CHECK_HI;
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
          end
        end
        CHECK_HI: begin
          if (!s_w) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!s_w) begin
            state_q <= CHECK_LO;
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
          end
        end
        CHECK_LO: begin
          if (s_w) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
          level_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// ---------------------------------------------------------------
// tb_input_debouncer: directed vector table plus reset/glitch sequences
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_input_debouncer;

  logic clk;
  logic reset;
  logic d_in;
  logic level_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // exp packs {level_out, rise_pulse, fall_pulse, busy} after the edge
  typedef struct {
    logic       d;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[36];

  input_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d_in       (d_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      assert (!(rise_pulse && fall_pulse))
        else $error("FAIL both_pulses: rise=%b fall=%b required not both 1", rise_pulse, fall_pulse);
    end
  end

  function automatic logic [3:0] outs();
    return {level_out, rise_pulse, fall_pulse, busy};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got {lvl,rise,fall,busy}=%b required %b", name, act, exp);
  endtask

  task automatic step(input logic d);
    @(negedge clk);
    d_in = d;
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; resets low for 1 time unit mid-cycle.
  task automatic pulse_reset_check(input string name);
    #2;
    reset = 1'b0;
    #1;
    check(name, outs(), 4'b0000);
    reset = 1'b1;
  endtask

  task automatic fill(input int lo, input int hi, input logic d, input logic [3:0] e);
    for (int i = lo; i <= hi; i++) vecs[i] = '{d, e};
  endtask

  initial begin
    fill( 0,  1, 1'b0, 4'b0000);
    fill( 2,  3, 1'b1, 4'b0000);
    fill( 4,  6, 1'b1, 4'b0001);
    fill( 7,  7, 1'b1, 4'b1100);
    fill( 8, 11, 1'b1, 4'b1000);
    fill(12, 13, 1'b0, 4'b1000);
    fill(14, 14, 1'b0, 4'b1001);
    fill(15, 16, 1'b1, 4'b1001);
    fill(17, 19, 1'b1, 4'b1000);
    fill(20, 21, 1'b0, 4'b1000);
    fill(22, 24, 1'b0, 4'b1001);
    fill(25, 25, 1'b0, 4'b0010);
    fill(26, 27, 1'b0, 4'b0000);
    fill(28, 29, 1'b1, 4'b0000);
    fill(30, 30, 1'b1, 4'b0001);
    fill(31, 32, 1'b0, 4'b0001);
    fill(33, 35, 1'b0, 4'b0000);

    reset = 1'b0;
    d_in  = 1'b0;
    #2;
    check("reset_state", outs(), 4'b0000);
    @(negedge clk);
    reset = 1'b1;

    // Rise after 10-cycle hold, rejected low glitch, fall, rejected high glitch
    for (int i = 0; i < 36; i++) begin
      step(vecs[i].d);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Reset while qualifying a rise, then requalify with d_in still high
    for (int i = 0; i < 3; i++) step(1'b1);
    check("busy_before_reset", outs(), 4'b0001);
    pulse_reset_check("reset_mid_check_hi");
    for (int n = 1; n <= 7; n++) begin
      logic [3:0] e;
      if (n < 3)       e = 4'b0000;
      else if (n < 6)  e = 4'b0001;
      else if (n == 6) e = 4'b1100;
      else             e = 4'b1000;
      step(1'b1);
      check($sformatf("post_reset_edge%0d", n), outs(), e);
    end

    // Reset while level is high drops it at once; low input keeps it low
    step(1'b1);
    pulse_reset_check("reset_level_hi");
    for (int n = 0; n < 4; n++) begin
      step(1'b0);
      check($sformatf("after_reset_low%0d", n), outs(), 4'b0000);
    end

    // Toggling every cycle never qualifies
    for (int i = 0; i < 50; i++) begin
      step((i % 2) == 0);
      check($sformatf("alternate%0d", i), outs() & 4'b1110, 4'b0000);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
